// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse meter: FSM encoding and default counter width.
package pulse_meter_pkg;
  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pm_state_e;
endpackage

// File: rtl/pulse_meter_sync_edge.sv
// Two-flop synchronizer with rise/fall detect; every flop resets to 1 so a line
// already high when reset releases never looks like a rising edge.
module pulse_meter_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic signal,
  output logic s,
  output logic rise,
  output logic fall
);
  logic s1, s_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1  <= 1'b1;
      s   <= 1'b1;
      s_d <= 1'b1;
    end else begin
      s1  <= signal;
      s   <= s1;
      s_d <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
endmodule

// File: rtl/pulse_meter.sv
// Measures high time and rise-to-rise period of an asynchronous pulse line and
// hands each finished measurement out on a valid/ready register.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             signal,
  output logic [WIDTH-1:0] meas_high,
  output logic [WIDTH-1:0] meas_period,
  output logic             meas_sat,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun,
  output logic             armed
);
  localparam logic [WIDTH-1:0] CMAX = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  pm_state_e        state, nstate;
  logic             s, rise, fall, emit;
  logic [WIDTH-1:0] hi_cnt, lo_cnt;
  logic [WIDTH:0]   sum;
  logic             sat_now;

  pulse_meter_sync_edge u_sync (
    .clock  (clock),
    .reset  (reset),
    .signal (signal),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (rise) nstate = HIGH;
      HIGH:    if (fall) nstate = LOW;
      LOW:     if (rise) nstate = HIGH;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    armed = (state == HIGH) || (state == LOW);
    emit  = (state == LOW) && rise;
  end

  // Counters stick at CMAX; a stuck counter forces the saturated result.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (rise) begin
          hi_cnt <= ONE;
          lo_cnt <= '0;
        end
        HIGH: begin
          if (fall)                     lo_cnt <= ONE;
          else if (s && hi_cnt != CMAX) hi_cnt <= hi_cnt + ONE;
        end
        LOW: begin
          if (rise) begin
            hi_cnt <= ONE;
            lo_cnt <= '0;
          end else if (!s && lo_cnt != CMAX) begin
            lo_cnt <= lo_cnt + ONE;
          end
        end
        default: begin
          hi_cnt <= '0;
          lo_cnt <= '0;
        end
      endcase
    end
  end

  assign sum     = {1'b0, hi_cnt} + {1'b0, lo_cnt};
  assign sat_now = (hi_cnt == CMAX) || (lo_cnt == CMAX) || sum[WIDTH];

  always_ff @(posedge clock) begin
    if (!reset) begin
      meas_high   <= '0;
      meas_period <= '0;
      meas_sat    <= 1'b0;
      meas_valid  <= 1'b0;
      overrun     <= 1'b0;
    end else if (emit && (!meas_valid || meas_ready)) begin
      meas_high   <= hi_cnt;
      meas_period <= sat_now ? CMAX : sum[WIDTH-1:0];
      meas_sat    <= sat_now;
      meas_valid  <= 1'b1;
    end else begin
      if (emit)                     overrun    <= 1'b1;
      if (meas_valid && meas_ready) meas_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: default-width instance plus a WIDTH=4 instance
// sharing clock, reset, signal and ready.
module tb_pulse_meter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        signal = 1'b1;
  logic        ready = 1'b0;
  logic [15:0] m_high, m_period;
  logic        m_sat, m_valid, m_ovr, m_armed;
  logic [3:0]  q_high, q_period;
  logic        q_sat, q_valid, q_ovr, q_armed;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  pulse_meter u_dut (
    .clock(clock), .reset(reset), .signal(signal),
    .meas_high(m_high), .meas_period(m_period), .meas_sat(m_sat),
    .meas_valid(m_valid), .meas_ready(ready), .overrun(m_ovr), .armed(m_armed)
  );

  pulse_meter #(.WIDTH(4)) u_dut4 (
    .clock(clock), .reset(reset), .signal(signal),
    .meas_high(q_high), .meas_period(q_period), .meas_sat(q_sat),
    .meas_valid(q_valid), .meas_ready(ready), .overrun(q_ovr), .armed(q_armed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    signal = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic pulse(input int h, input int l);
    signal = 1'b1;
    repeat (h) tick();
    signal = 1'b0;
    repeat (l) tick();
  endtask

  initial begin
    // 1: reset with the line already high, then no false rise
    repeat (3) tick();
    check("rst_high", m_high, 0);
    check("rst_period", m_period, 0);
    check("rst_sat", m_sat, 0);
    check("rst_valid", m_valid, 0);
    check("rst_ovr", m_ovr, 0);
    check("rst_armed", m_armed, 0);
    reset = 1'b1;
    repeat (5) tick();
    check("t1_armed", m_armed, 0);
    check("t1_valid", m_valid, 0);

    // 2: 4 high / 6 low, three times, consumer always ready
    ready  = 1'b1;
    signal = 1'b0;
    repeat (4) tick();
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 10; c++) begin
        signal = (c < 4);
        tick();
        check("t2_valid", m_valid, (p >= 1 && c == 2) ? 1 : 0);
        if (p >= 1 && c == 2) begin
          check("t2_high", m_high, 4);
          check("t2_period", m_period, 10);
          check("t2_sat", m_sat, 0);
        end
      end
    end

    // 3: consumer stalled, second result dropped
    do_reset();
    ready = 1'b0;
    pulse(2, 3);
    pulse(2, 3);
    check("t3_valid", m_valid, 1);
    check("t3_high", m_high, 2);
    check("t3_period", m_period, 5);
    check("t3_ovr_pre", m_ovr, 0);
    signal = 1'b1;
    repeat (3) tick();
    check("t3_ovr", m_ovr, 1);
    check("t3_hold_high", m_high, 2);
    check("t3_hold_period", m_period, 5);
    check("t3_hold_valid", m_valid, 1);
    ready = 1'b1;
    tick();
    check("t3_accept_valid", m_valid, 0);
    check("t3_ovr_sticky", m_ovr, 1);

    // 4: saturation on the 4-bit instance
    do_reset();
    check("t4_ovr_cleared", m_ovr, 0);
    pulse(10, 10);
    signal = 1'b1;
    repeat (3) tick();
    check("t4_q_valid", q_valid, 1);
    check("t4_q_high", q_high, 10);
    check("t4_q_period", q_period, 15);
    check("t4_q_sat", q_sat, 1);
    check("t4_m_high", m_high, 10);
    check("t4_m_period", m_period, 20);
    check("t4_m_sat", m_sat, 0);
    repeat (17) tick();
    signal = 1'b0;
    repeat (2) tick();
    signal = 1'b1;
    repeat (3) tick();
    check("t4_q_valid2", q_valid, 1);
    check("t4_q_high_hold", q_high, 15);
    check("t4_q_period2", q_period, 15);
    check("t4_q_sat2", q_sat, 1);
    check("t4_m_high2", m_high, 20);
    check("t4_m_period2", m_period, 22);

    // 5: reset in the middle of a LOW phase
    signal = 1'b0;
    repeat (4) tick();
    check("t5_armed_pre", m_armed, 1);
    do_reset();
    check("t5_armed", m_armed, 0);
    check("t5_valid", m_valid, 0);
    pulse(3, 3);
    signal = 1'b1;
    repeat (3) tick();
    check("t5_valid_res", m_valid, 1);
    check("t5_high", m_high, 3);
    check("t5_period", m_period, 6);
    check("t5_sat", m_sat, 0);
    check("t5_ovr", m_ovr, 0);

    // 6: period-2 pulses; ready lines up with each emit so accept and load coincide
    do_reset();
    for (int k = 0; k < 20; k++) begin
      signal = (k % 2 == 0);
      ready  = signal;
      tick();
      if (k >= 4) begin
        check("t6_valid", m_valid, 1);
        check("t6_high", m_high, 1);
        check("t6_period", m_period, 2);
        check("t6_ovr", m_ovr, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
